// File: rtl/tbus_turnaround_arb.sv
// rtl/tbus_turnaround_arb.sv - round-robin owner arbiter for a shared tri-state output bank
module tbus_turnaround_arb #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           C,
  input  logic           CLR_N,
  input  logic           FORCE_Z,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] DATA,
  output logic [N-1:0]   GNT,
  output logic [W-1:0]   BUS_I,
  output logic [W-1:0]   BUS_T,
  output logic           BUSY
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   bus_i_q, bus_i_d;
  logic           t_q, t_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [TW-1:0]  tenure_q, tenure_d;
  logic [CW-1:0]  turn_q, turn_d;

  logic           win_found;
  logic [PW-1:0]  win_idx;
  logic           others_req;
  logic           hold_hit;

  // Search requesters starting just after the last owner so every requester gets a turn
  always_comb begin
    int k;
    logic [PW-1:0] k_idx;
    win_found = 1'b0;
    win_idx   = rr_q;
    k         = 0;
    k_idx     = '0;
    for (int i = 1; i <= N; i++) begin
      k     = (int'(rr_q) + i) % N;
      k_idx = PW'(k);
      if (!win_found && REQ[k_idx]) begin
        win_found = 1'b1;
        win_idx   = k_idx;
      end
    end
  end

  assign others_req = |(REQ & ~gnt_q);
  assign hold_hit   = (MAX_HOLD != 0) && (tenure_q == TW'(MAX_HOLD));

  // State and registered outputs; reset releases the bus immediately via t_q
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      bus_i_q  <= '0;
      t_q      <= 1'b1;
      rr_q     <= PW'(N - 1);
      tenure_q <= '0;
      turn_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      bus_i_q  <= bus_i_d;
      t_q      <= t_d;
      rr_q     <= rr_d;
      tenure_q <= tenure_d;
      turn_q   <= turn_d;
    end
  end

  // Next-state: grant from IDLE, hold or release in DRIVE, count down the quiet gap in TURN
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    bus_i_d  = bus_i_q;
    t_d      = t_q;
    rr_d     = rr_q;
    tenure_d = tenure_q;
    turn_d   = turn_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !FORCE_Z) begin
          state_d          = S_DRIVE;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          t_d              = 1'b0;
          bus_i_d          = DATA[win_idx*W +: W];
          rr_d             = win_idx;
          tenure_d         = TW'(1);
        end
      end
      S_DRIVE: begin
        if (!REQ[rr_q] || FORCE_Z || (hold_hit && others_req)) begin
          state_d = S_TURN;
          gnt_d   = '0;
          t_d     = 1'b1;
          turn_d  = CW'(TURN_CYC);
        end else begin
          bus_i_d = DATA[rr_q*W +: W];
          if ((MAX_HOLD != 0) && !hold_hit) begin
            tenure_d = tenure_q + 1'b1;
          end
        end
      end
      S_TURN: begin
        if (turn_q <= CW'(1)) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        t_d     = 1'b1;
      end
    endcase
  end

  // Force-Z overrides the enable combinationally so the bus floats in the same cycle
  always_comb begin
    GNT   = gnt_q;
    BUS_I = bus_i_q;
    BUS_T = {W{t_q | FORCE_Z}};
    BUSY  = (state_q != S_IDLE);
  end

endmodule
